// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the LSU/fetch requesters, the arbiter and the shared memory.
// slave = arbiter view, master = requester/memory (environment) view.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             lsu_req;
  logic [WIDTH-1:0] lsu_addr;
  logic [WIDTH-1:0] lsu_wdata;
  logic             lsu_we;
  logic             lsu_gnt;
  logic             lsu_rvalid;
  logic [WIDTH-1:0] lsu_rdata;

  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;

  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  // Handshake: a requester raises req with addr/wdata/we stable and holds all of
  // them until the cycle gnt is high; the transfer is accepted in that cycle and
  // inputs may change in the next. Exactly one rvalid cycle follows two cycles later.
  modport slave (
    input  lsu_req, lsu_addr, lsu_wdata, lsu_we,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output lsu_req, lsu_addr, lsu_wdata, lsu_we,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the LSU
// and instruction fetch, sequencing each access through IDLE -> ACCESS -> RESP.
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t           state_q;
  logic             owner_q;
  logic             last_owner_q;
  logic             we_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic             lsu_rvalid_q;
  logic             if_rvalid_q;

  logic eligible;
  logic pick_lsu;
  logic lsu_gnt_c;
  logic if_gnt_c;

  // On a tie the port that did not win last time is chosen; gnt is masked in reset.
  always_comb begin
    eligible  = (state_q == IDLE) || (state_q == RESP);
    pick_lsu  = bus.lsu_req && (!bus.if_req || (last_owner_q == OWN_IF));
    lsu_gnt_c = !rst && eligible && pick_lsu;
    if_gnt_c  = !rst && eligible && bus.if_req && !pick_lsu;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      lsu_rvalid_q <= 1'b0;
      if_rvalid_q  <= 1'b0;
    end else begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      lsu_rvalid_q <= 1'b0;
      if_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (lsu_gnt_c) begin
            owner_q      <= OWN_LSU;
            last_owner_q <= OWN_LSU;
            we_q         <= bus.lsu_we;
            mem_en_q     <= 1'b1;
            mem_we_q     <= bus.lsu_we;
            mem_addr_q   <= bus.lsu_addr;
            mem_wdata_q  <= bus.lsu_wdata;
            state_q      <= ACCESS;
          end else if (if_gnt_c) begin
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b1;
            mem_addr_q   <= bus.if_addr;
            state_q      <= ACCESS;
          end else begin
            state_q      <= IDLE;
          end
        end
        ACCESS: begin
          lsu_rvalid_q <= (owner_q == OWN_LSU);
          if_rvalid_q  <= (owner_q == OWN_IF);
          state_q      <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // mem_rdata is valid in RESP, so read data is steered straight through to the owner.
  always_comb begin
    bus.lsu_gnt    = lsu_gnt_c;
    bus.if_gnt     = if_gnt_c;
    bus.lsu_rvalid = lsu_rvalid_q;
    bus.if_rvalid  = if_rvalid_q;
    bus.lsu_rdata  = (lsu_rvalid_q && !we_q) ? bus.mem_rdata : '0;
    bus.if_rdata   = if_rvalid_q ? bus.mem_rdata : '0;
    bus.mem_en     = mem_en_q;
    bus.mem_we     = mem_we_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
    dbg_state_o    = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous memory model and
// hand-computed expected values for every cycle checked.
module tb_mem_port_arbiter;

  localparam int W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mem_port_arbiter_if #(.WIDTH(W)) bus ();

  mem_port_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: one-cycle read latency, write on mem_en && mem_we
  logic [W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_we ? '0 : mem[bus.mem_addr[9:2]];
    end
  end

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_lsu(input logic req, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata, input logic we);
    bus.lsu_req   = req;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wdata;
    bus.lsu_we    = we;
  endtask

  task automatic drive_if(input logic req, input logic [W-1:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, bus.lsu_gnt, bus.if_gnt, bus.lsu_rvalid,
                          bus.if_rvalid, bus.mem_en, bus.mem_we}, 32'd0);
    check({tag, "_dat"}, bus.mem_addr | bus.mem_wdata | bus.lsu_rdata | bus.if_rdata, 32'd0);
  endtask

  logic [1:0] exp_gnt [8];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h0000_0013;   // word at byte address 0x100
    bus.mem_rdata = '0;
    rst = 1'b1;
    drive_lsu(1'b0, '0, '0, 1'b0);
    drive_if(1'b0, '0);

    // reset then idle
    tick(); settle();
    check_all_zero("reset");
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      check_all_zero("idle");
    end

    // single LSU store
    tick(); drive_lsu(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1); settle();
    check("st_gnt", {30'd0, bus.lsu_gnt, bus.if_gnt}, 32'd2);
    tick(); drive_lsu(1'b0, '0, '0, 1'b0); settle();
    check("st_en_we_gnt", {28'd0, bus.mem_en, bus.mem_we, bus.lsu_gnt, bus.if_gnt}, 32'hC);
    check("st_addr", bus.mem_addr, 32'h10);
    check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick(); settle();
    check("st_rvalid", {30'd0, bus.lsu_rvalid, bus.if_rvalid}, 32'd2);
    check("st_rdata", bus.lsu_rdata, 32'd0);
    check("st_mem_idle", {31'd0, bus.mem_en}, 32'd0);

    // single fetch
    tick(); drive_if(1'b1, 32'h100); settle();
    check("if_gnt", {30'd0, bus.lsu_gnt, bus.if_gnt}, 32'd1);
    tick(); drive_if(1'b0, '0); settle();
    check("if_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd2);
    check("if_addr", bus.mem_addr, 32'h100);
    check("if_lsu_rv1", {31'd0, bus.lsu_rvalid}, 32'd0);
    tick(); settle();
    check("if_rvalid", {30'd0, bus.lsu_rvalid, bus.if_rvalid}, 32'd1);
    check("if_rdata", bus.if_rdata, 32'h13);
    check("if_lsu_rdata", bus.lsu_rdata, 32'd0);

    // contention from reset: asynchronous reset mid-run with both requesting
    tick(); drive_lsu(1'b1, 32'h10, '0, 1'b0); drive_if(1'b1, 32'h100);
    rst = 1'b1; settle();
    check_all_zero("rst_async");
    exp_gnt = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      settle();
      check($sformatf("rr_gnt%0d", i), {30'd0, bus.lsu_gnt, bus.if_gnt}, {30'd0, exp_gnt[i]});
    end
    tick(); drive_lsu(1'b0, '0, '0, 1'b0); drive_if(1'b0, '0); settle();
    check("rr_last_rv", {30'd0, bus.lsu_rvalid, bus.if_rvalid}, 32'd1);
    check("rr_last_data", bus.if_rdata, 32'h13);
    tick(); settle();
    check_all_zero("rr_drain");

    // store then back-to-back load
    tick(); drive_lsu(1'b1, 32'h20, 32'hCAFE_F00D, 1'b1); settle();
    check("sl_st_gnt", {31'd0, bus.lsu_gnt}, 32'd1);
    tick(); drive_lsu(1'b1, 32'h20, '0, 1'b0); settle();
    check("sl_no_gnt_access", {30'd0, bus.lsu_gnt, bus.if_gnt}, 32'd0);
    check("sl_st_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    tick(); settle();
    check("sl_ack_and_gnt", {29'd0, bus.lsu_rvalid, bus.lsu_gnt, bus.if_gnt}, 32'd6);
    check("sl_ack_rdata", bus.lsu_rdata, 32'd0);
    tick(); drive_lsu(1'b0, '0, '0, 1'b0); settle();
    check("sl_ld_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd2);
    check("sl_ld_addr", bus.mem_addr, 32'h20);
    tick(); settle();
    check("sl_ld_rvalid", {31'd0, bus.lsu_rvalid}, 32'd1);
    check("sl_ld_rdata", bus.lsu_rdata, 32'hCAFE_F00D);

    // reset mid-access
    tick(); settle();
    tick(); drive_lsu(1'b1, 32'h10, '0, 1'b0); settle();
    check("ra_gnt", {31'd0, bus.lsu_gnt}, 32'd1);
    tick(); drive_lsu(1'b0, '0, '0, 1'b0); settle();
    check("ra_access", {31'd0, bus.mem_en}, 32'd1);
    rst = 1'b1; settle();
    check_all_zero("ra_rst");
    tick(); settle();
    check_all_zero("ra_rst_hold");
    tick(); rst = 1'b0; drive_if(1'b1, 32'h100); settle();
    check("ra_if_gnt", {29'd0, bus.lsu_rvalid, bus.lsu_gnt, bus.if_gnt}, 32'd1);
    tick(); drive_if(1'b0, '0); settle();
    check("ra_if_en", {31'd0, bus.mem_en}, 32'd1);
    check("ra_if_addr", bus.mem_addr, 32'h100);
    tick(); settle();
    check("ra_if_rv", {30'd0, bus.lsu_rvalid, bus.if_rvalid}, 32'd1);
    check("ra_if_rdata", bus.if_rdata, 32'h13);
    tick(); settle();
    check_all_zero("ra_end");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // overall time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer that shares one single-port synchronous memory between the load/store unit (address, write data and write enable already resolved) and instruction fetch (read-only). It sits between the core's LSU and fetch stage on one side and the unified memory on the other. It issues one access at a time through a fixed three-state sequence, returns read data to the owning requester, and uses round-robin arbitration so neither port starves.

## Interface
- WIDTH, 32, address and data width for all ports
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- lsu_req  in  1  LSU access request; held until lsu_gnt
- lsu_addr  in  WIDTH  LSU byte address
- lsu_wdata  in  WIDTH  LSU store data
- lsu_we  in  1  1 = store, 0 = load
- lsu_gnt  out  1  request accepted this cycle (combinational)
- lsu_rvalid  out  1  LSU response cycle (load data or store ack)
- lsu_rdata  out  WIDTH  load data, valid when lsu_rvalid
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  WIDTH  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch response cycle
- if_rdata  out  WIDTH  instruction word, valid when if_rvalid
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  WIDTH  memory address (registered)
- mem_wdata  out  WIDTH  memory write data (registered)
- mem_rdata  in  WIDTH  memory read data; valid the cycle after mem_en

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, owner (LSU/IF), last_owner, latched addr/wdata/we.
- Arbitration occurs only in IDLE and RESP, which are the grant-eligible states:
  - Only one req: grant it.
  - Both: grant the port that is not last_owner.
  - On grant: latch owner, address, wdata (IF: 0), we (IF: 0); set last_owner = granted port; next state ACCESS.
- IDLE: no req → stay IDLE.
- ACCESS: mem_en=1, mem_addr/mem_wdata/mem_we from latched values; gnt outputs 0; next state RESP unconditionally.
- RESP: owner's rvalid=1.
  - Owner's rdata = mem_rdata for loads and fetches; 0 for stores.
  - Non-owner rvalid=0, rdata=0.
  - Arbitrate as in IDLE: on grant → ACCESS, otherwise → IDLE.
- Only one gnt is high per cycle. gnt is never high in ACCESS.
- Requester handshake: req, addr, wdata and we are stable from req assertion through the gnt cycle. They may change in the cycle after gnt.
- When mem_en=0: mem_we=0, mem_addr=0, mem_wdata=0.
- When rvalid=0: rdata=0.
- Reset, asynchronous: state=IDLE, last_owner=IF (the first tie goes to LSU), latched values 0, all outputs 0. An in-flight access is dropped with no rvalid. After reset deassertion the first grant is possible in the same cycle.

## Timing
- Request seen in IDLE at cycle N:
  - gnt at N.
  - mem_en at N+1.
  - rvalid/rdata at N+2.
- Back-to-back: a grant in RESP (cycle N+2) gives mem_en at N+3. Sustained throughput is one access per 2 cycles.
- Store commits at the N+1 clock edge (memory samples mem_we with mem_en). Ack (rvalid) arrives at N+2.
- A request arriving while in ACCESS waits. Its earliest grant is the following RESP cycle.
- Both requesting continuously: grants alternate LSU, IF, LSU, …, one every 2 cycles.

## Test plan
- Reset then idle: rst=1 mid-run → all outputs 0 asynchronously; with no req after release, outputs stay 0 for 5 cycles.
- Single LSU store: lsu_req=1, addr=0x10, wdata=0xDEADBEEF, we=1 → lsu_gnt at N; at N+1 mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; at N+2 lsu_rvalid=1, lsu_rdata=0.
- Single fetch: if_req=1, if_addr=0x100, memory model returns 0x00000013 → if_gnt at N; at N+1 mem_en=1, mem_we=0, mem_addr=0x100; at N+2 if_rvalid=1, if_rdata=0x13; lsu_rvalid=0 throughout.
- Contention and round-robin: both req held continuously from reset → grant order LSU, IF, LSU, IF at cycles N, N+2, N+4, N+6; never two gnts in the same cycle.
- Store-then-load ordering: LSU store 0xCAFEF00D to 0x20, then LSU load 0x20 requested back-to-back → load's lsu_rdata=0xCAFEF00D; load gnt comes in the store's RESP cycle.
- Reset mid-access: assert rst during ACCESS of an LSU load → no lsu_rvalid follows; after release, a new if_req is granted the same cycle and completes normally.
